lstm_seq_ctrl: RTL
==================

# lstm_seq_ctrl

Timestep sequencer that sits directly upstream of the `lstm` layer and drives it. It accepts a sequence of input frames over a valid/ready handshake and presents each frame on the layer's `i_x`. For every timestep it drives `sel`, `load_h` and `wr`, waits the layer's forward latency, captures `o_h` into a history buffer for backpropagation, and hands the final hidden vector downstream.

## Interface
Parameters:
- `WIDTH`, 32, fixed-point word width
- `NUM`, 68, input features per frame
- `NUM_LSTM`, 8, cells in the layer
- `SEQ_LEN`, 8, maximum timesteps per sequence (≥1)
- `LEN_W`, 4, width of `i_len`; must hold `SEQ_LEN`
- `ADDR_W`, 3, width of `i_rd_addr`; `2**ADDR_W ≥ SEQ_LEN`
- `LAT`, 4, cycles from `o_x`/`o_sel` stable until `i_h` is valid (≥1)

Ports:
- `clk`, in, 1, clock
- `rst`, in, 1, reset; asynchronous, active-low
- `i_start`, in, 1, start-sequence request
- `i_len`, in, `LEN_W`, sequence length; sampled with `i_start`
- `i_valid`, in, 1, input frame valid
- `o_ready`, out, 1, frame accepted when `i_valid & o_ready`
- `i_frame`, in, `NUM*WIDTH`, input frame
- `o_x`, out, `NUM*WIDTH`, registered frame driven to the layer's `i_x`
- `o_sel`, out, 1, layer `sel`: 0 selects a zero recurrent input, 1 selects `h_prev`
- `o_load_h`, out, 1, layer `load_h` pulse
- `o_wr`, out, 1, layer `wr` pulse (weight/bias write-back)
- `i_h`, in, `NUM_LSTM*WIDTH`, layer `o_h`
- `i_upd`, in, 1, weight-update request from the backprop unit
- `o_h_valid`, out, 1, final hidden vector valid
- `i_h_ready`, in, 1, downstream accepts `o_h_last`
- `o_h_last`, out, `NUM_LSTM*WIDTH`, hidden vector of the last timestep
- `i_rd_addr`, in, `ADDR_W`, history read index
- `o_rd_h`, out, `NUM_LSTM*WIDTH`, `hist[i_rd_addr]`, combinational read
- `o_t`, out, `LEN_W`, current timestep index
- `o_busy`, out, 1, high in every state except IDLE

## Operation
- **States:** IDLE, LOAD, WAIT, LATCH, DONE, UPD.
- **IDLE:**
  - `i_start` with `i_len`≠0 → LOAD; latch `len = min(i_len, SEQ_LEN)`, set `t = 0`.
  - `i_start` with `i_len`=0 is ignored.
  - Else `i_upd` → UPD. `i_start` has priority over `i_upd` in the same cycle.
- **LOAD:**
  - `o_ready=1`. On handshake: `o_x <= i_frame`, `o_sel <= (t≠0)`, counter ← `LAT-1`, → WAIT.
  - `i_start` and `i_upd` are ignored in every state except IDLE.
- **WAIT:** decrement the counter; at 0 → LATCH.
- **LATCH:**
  - `o_load_h=1` for exactly this cycle; `hist[t] <= i_h`, `o_h_last <= i_h`.
  - If `t == len-1` → DONE, else `t <= t+1`, → LOAD.
- **DONE:** `o_h_valid=1`; `o_h_last` is held stable. When `i_h_ready=1` → IDLE.
- **UPD:** `o_wr=1` for one cycle → IDLE.
- `o_x` and `o_sel` hold their values from acceptance through LATCH and until the next acceptance.
- `hist` entries ≥ `len` keep stale data. Reading an address ≥ `SEQ_LEN` returns 0.
- No arithmetic on data words; the block is a pure data mover. `t` never exceeds `SEQ_LEN-1`.

## Timing
- **Reset (`rst`=0, asynchronous):** state=IDLE; `o_x`, `o_h_last`, every `hist` entry, `t`, counter = 0; `o_ready`, `o_sel`, `o_load_h`, `o_wr`, `o_h_valid`, `o_busy` = 0.
- **Reset mid-sequence:** everything is cleared immediately and no further pulses are issued. The layer's internal h/c state is not cleared by this block.
- **Per-timestep cycle budget:**
  - Frame accepted at cycle k.
  - `o_x`/`o_sel` valid from k+1.
  - WAIT occupies k+1 … k+LAT.
  - LATCH is cycle k+LAT+1: `i_h` is sampled and `o_load_h` pulses.
  - LOAD again at k+LAT+2.
- Steady throughput is one timestep per LAT+2 cycles when `i_valid` is held high.
- `o_ready` is a registered state decode and does not depend combinationally on `i_valid`.
- `o_h_valid` rises the cycle after the final LATCH. It stays high until the cycle `i_h_ready` is sampled high, then drops in the next cycle.
- `i_h_ready` is don't-care outside DONE.

## Structure
- **Shared package:** state encodings (3-bit localparams), and `WIDTH`, `NUM`, `NUM_LSTM` defaults shared with the layer.
- **One sub-module:** `lstm_hist_buf`, a `SEQ_LEN` × `NUM_LSTM*WIDTH` register file with async-low clear, a write-enable/index port, and a combinational read port. The FSM, timestep counter and latency counter stay in `lstm_seq_ctrl`.

## Test plan
All scenarios use LAT=4, SEQ_LEN=4.
- **Reset values:** reset, then release → all outputs 0 and `o_busy`=0; `o_ready`=0 until `i_start`.
- **Three-frame sequence:** `i_start`, `i_len`=3, frames F0/F1/F2 with `i_valid` held, `i_h` = 0x11/0x22/0x33 per step →
  - `o_sel` = 0, 1, 1.
  - Three `o_load_h` pulses spaced 6 cycles apart.
  - `hist[0..2]` = 0x11/0x22/0x33; `o_h_last` = 0x33 with `o_h_valid`.
- **Downstream backpressure:** `i_h_ready`=0 for 5 cycles in DONE → `o_h_valid` and `o_h_last` held stable; IDLE is entered one cycle after `i_h_ready`=1.
- **Length boundaries:**
  - `i_len`=0 → stays IDLE.
  - `i_len`=9 → clamped to 4: exactly 4 frames accepted, `o_t` peaks at 3.
- **Simultaneous and ignored requests:** `i_start` and `i_upd` together in IDLE → sequence starts, `o_wr` stays 0. `i_upd` alone → one-cycle `o_wr` pulse, then IDLE. `i_upd` during WAIT is ignored.
- **Reset mid-WAIT:** `rst` low during WAIT of step 1 → immediate IDLE, `o_load_h` never pulses, `o_rd_h` reads 0 for all addresses.

Source files
------------

// File: rtl/lstm_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lstm_seq_ctrl_pkg
// Description : Shared constants for the LSTM timestep sequencer. Holds the
//               sequencer state encodings and the word/vector size defaults
//               shared with the lstm layer.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_seq_ctrl_pkg;

    // Data word and vector size defaults, matching the lstm layer
    localparam int c_def_width    = 32;
    localparam int c_def_num      = 68;
    localparam int c_def_num_lstm = 8;

    // Sequencer state encodings
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_latch = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
    localparam logic [2:0] c_st_upd   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/lstm_hist_buf.sv
`default_nettype none
// ============================================================================
// Module      : lstm_hist_buf
// Description : Hidden-state history register file. DEPTH entries of DW bits,
//               asynchronous active-low clear, single indexed write port and
//               a combinational read port. Addresses outside the populated
//               range read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_hist_buf #(
    parameter int DEPTH  = 8,
    parameter int DW     = 256,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_idx,
    input  logic [DW-1:0]     i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DW-1:0]     o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    // Entry storage: cleared on reset, one entry written per enabled cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_wr_idx == ADDR_W'(i)) begin
                    r_mem[i] <= i_wr_data;
                end
            end
        end
    end

    // Read mux: compare against every implemented entry so that unused
    // addresses fall through to zero without an out-of-range index
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lstm_seq_ctrl
// Description : Timestep sequencer for the lstm layer. Accepts input frames,
//               drives the layer's x/sel/load_h/wr controls, waits the layer
//               latency, records each hidden vector in a history buffer and
//               hands the final hidden vector downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_seq_ctrl
    import lstm_seq_ctrl_pkg::*;
#(
    parameter int WIDTH    = c_def_width,
    parameter int NUM      = c_def_num,
    parameter int NUM_LSTM = c_def_num_lstm,
    parameter int SEQ_LEN  = 8,
    parameter int LEN_W    = 4,
    parameter int ADDR_W   = 3,
    parameter int LAT      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM*WIDTH-1:0]     i_frame,
    output logic [NUM*WIDTH-1:0]     o_x,
    output logic                     o_sel,
    output logic                     o_load_h,
    output logic                     o_wr,
    input  logic [NUM_LSTM*WIDTH-1:0] i_h,
    input  logic                     i_upd,
    output logic                     o_h_valid,
    input  logic                     i_h_ready,
    output logic [NUM_LSTM*WIDTH-1:0] o_h_last,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic [NUM_LSTM*WIDTH-1:0] o_rd_h,
    output logic [LEN_W-1:0]         o_t,
    output logic                     o_busy
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int HW    = NUM_LSTM * WIDTH;
    localparam int FW    = NUM * WIDTH;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_t;
    logic [CNT_W-1:0] r_cnt;
    logic [FW-1:0]    r_x;
    logic             r_sel;
    logic [HW-1:0]    r_h_last;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_last;
    logic             w_latch;
    logic [LEN_W-1:0] w_len_clamped;

    assign w_start_ok    = i_start && (i_len != '0);
    assign w_accept      = (r_state == c_st_load) && i_valid;
    assign w_last        = (r_t == r_len - LEN_W'(1));
    assign w_latch       = (r_state == c_st_latch);
    assign w_len_clamped = (i_len > LEN_W'(SEQ_LEN)) ? LEN_W'(SEQ_LEN) : i_len;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests are only honoured in IDLE, start wins over update
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start_ok) begin
                    w_state_nxt = c_st_load;
                end else if (i_upd) begin
                    w_state_nxt = c_st_upd;
                end
            end
            c_st_load: begin
                if (i_valid) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_latch;
                end
            end
            c_st_latch: begin
                w_state_nxt = w_last ? c_st_done : c_st_load;
            end
            c_st_done: begin
                if (i_h_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_upd: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Sequence length, timestep index, latency counter and layer-facing registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len    <= '0;
            r_t      <= '0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_sel    <= 1'b0;
            r_h_last <= '0;
        end else begin
            if ((r_state == c_st_idle) && w_start_ok) begin
                r_len <= w_len_clamped;
                r_t   <= '0;
            end
            if (w_accept) begin
                r_x   <= i_frame;
                r_sel <= (r_t != '0);
                r_cnt <= CNT_W'(LAT - 1);
            end
            if ((r_state == c_st_wait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_latch) begin
                r_h_last <= i_h;
                if (!w_last) begin
                    r_t <= r_t + LEN_W'(1);
                end
            end
        end
    end

    lstm_hist_buf #(
        .DEPTH  (SEQ_LEN),
        .DW     (HW),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_latch),
        .i_wr_idx  (ADDR_W'(r_t)),
        .i_wr_data (i_h),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_h)
    );

    // Control outputs are pure decodes of the registered state
    assign o_ready   = (r_state == c_st_load);
    assign o_load_h  = w_latch;
    assign o_wr      = (r_state == c_st_upd);
    assign o_h_valid = (r_state == c_st_done);
    assign o_busy    = (r_state != c_st_idle);
    assign o_x       = r_x;
    assign o_sel     = r_sel;
    assign o_h_last  = r_h_last;
    assign o_t       = r_t;

endmodule
`default_nettype wire
